// File: rtl/bit_serializer.sv
// Parallel-to-serial producer feeding a 1-bit FIFO through its enq/din/full write port.
// Optionally appends an even-parity bit; stalls bit-for-bit while the FIFO is full.
module bit_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic                                in_valid,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                in_ready,
    output logic                                enq,
    output logic                                din,
    input  logic                                full,
    output logic                                busy,
    output logic [$clog2(DATA_WIDTH+1)-1:0]     bit_idx,
    output logic [15:0]                         words_sent
);

    localparam int unsigned IDX_W    = $clog2(DATA_WIDTH + 1);
    localparam int unsigned NBITS    = DATA_WIDTH + ((PARITY_EN != 0) ? 1 : 0);
    localparam int unsigned LAST_IDX = NBITS - 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    parity_q;
    logic                    data_bit;
    logic                    parity_phase;
    logic                    xfer;

    // The next data bit always sits at the shift-out end of the register.
    assign data_bit     = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
    assign parity_phase = (PARITY_EN != 0) && (bit_idx == IDX_W'(DATA_WIDTH));
    assign xfer         = (state == S_SHIFT) && !full;

    // Write strobe follows full within the same cycle so no bit slot is wasted.
    assign enq      = xfer;
    assign din      = (state == S_SHIFT) ? (parity_phase ? parity_q : data_bit) : 1'b0;
    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_SHIFT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            shreg      <= '0;
            parity_q   <= 1'b0;
            bit_idx    <= '0;
            words_sent <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        parity_q <= ^in_data;
                        bit_idx  <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (xfer) begin
                        if (bit_idx == IDX_W'(LAST_IDX)) begin
                            state      <= S_IDLE;
                            bit_idx    <= '0;
                            words_sent <= words_sent + 16'd1;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            if (MSB_FIRST != 0)
                                shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            else
                                shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized and directed bench for bit_serializer: an LSB-first instance and an
// MSB-first-with-parity instance share stimulus and are checked against a bit-list model.
module tb_bit_serializer;

    logic        CLK;
    logic        RST_N;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        full;

    logic        ready0, enq0, din0, busy0;
    logic [3:0]  idx0;
    logic [15:0] ws0;
    logic        ready1, enq1, din1, busy1;
    logic [3:0]  idx1;
    logic [15:0] ws1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model: the word as a list of bits in transmit order plus a cursor.
    logic [8:0]  m_bits  [2];
    int          m_pos   [2];
    int          m_len   [2];
    bit          m_busy  [2];
    logic [15:0] m_words [2];

    logic [15:0] cap0, cap1;
    int          ncap0, ncap1, sh0;

    bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready0), .enq(enq0), .din(din0), .full(full),
        .busy(busy0), .bit_idx(idx0), .words_sent(ws0)
    );

    bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready1), .enq(enq1), .din(din1), .full(full),
        .busy(busy1), .bit_idx(idx1), .words_sent(ws1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [8:0] build(input logic [7:0] w, input bit msb);
        logic [8:0] b;
        b = '0;
        for (int i = 0; i < 8; i++)
            b[i] = msb ? w[7-i] : w[i];
        b[8] = ^w;
        return b;
    endfunction

    task automatic check_dut(input int k, input logic rdy, input logic bsy, input logic e,
                             input logic d, input logic [3:0] idx, input logic [15:0] ws);
        logic exp_din;
        exp_din = m_busy[k] ? m_bits[k][m_pos[k]] : 1'b0;
        check($sformatf("d%0d_in_ready", k), 32'(rdy), 32'(!m_busy[k]));
        check($sformatf("d%0d_busy", k),     32'(bsy), 32'(m_busy[k]));
        check($sformatf("d%0d_enq", k),      32'(e),   32'(m_busy[k] && !full));
        check($sformatf("d%0d_din", k),      32'(d),   32'(exp_din));
        check($sformatf("d%0d_bit_idx", k),  32'(idx), 32'(m_busy[k] ? m_pos[k] : 0));
        check($sformatf("d%0d_words", k),    32'(ws),  32'(m_words[k]));
    endtask

    task automatic check_all();
        check_dut(0, ready0, busy0, enq0, din0, idx0, ws0);
        check_dut(1, ready1, busy1, enq1, din1, idx1, ws1);
        if (enq0 && ncap0 < 16) begin cap0[ncap0] = din0; ncap0++; end
        if (enq1 && ncap1 < 16) begin cap1[ncap1] = din1; ncap1++; end
        if (busy0) sh0++;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k]) begin
                if (!full) begin
                    m_pos[k]++;
                    if (m_pos[k] == m_len[k]) begin
                        m_busy[k]  = 1'b0;
                        m_pos[k]   = 0;
                        m_words[k] = m_words[k] + 16'd1;
                    end
                end
            end else if (in_valid) begin
                m_bits[k] = build(in_data, k == 1);
                m_pos[k]  = 0;
                m_busy[k] = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic f);
        @(negedge CLK);
        in_valid = v;
        in_data  = d;
        full     = f;
        #1;
        check_all();
        model_step();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N    = 1'b0;
        in_valid = 1'b0;
        full     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 1'b0;
            m_pos[k]   = 0;
            m_words[k] = '0;
        end
        #1;
        check_all();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic clear_cap();
        cap0 = '0; cap1 = '0; ncap0 = 0; ncap1 = 0; sh0 = 0;
    endtask

    // Drain until both instances are idle; an overrun counts as a failure.
    task automatic drain(input logic hv, input logic [7:0] hd, input logic [15:0] full_mask);
        int guard;
        guard = 0;
        while ((m_busy[0] || m_busy[1]) && guard < 100) begin
            cycle(hv, hd, (guard < 16) ? full_mask[guard] : 1'b0);
            guard++;
        end
        check("drain_timeout", 32'(guard < 100), 32'd1);
    endtask

    task automatic send(input logic [7:0] w, input logic [15:0] full_mask);
        clear_cap();
        cycle(1'b1, w, 1'b0);
        drain(1'b0, 8'h00, full_mask);
    endtask

    initial begin
        RST_N    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        full     = 1'b0;
        m_len[0] = 8;
        m_len[1] = 9;
        clear_cap();
        do_reset();

        // Idle after reset.
        repeat (3) cycle(1'b0, 8'h00, 1'b0);

        // Reset in the middle of a word: abandon it, nothing counted.
        cycle(1'b1, 8'hFF, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b0);
        do_reset();
        check("rst_words0", 32'(ws0), 32'd0);
        check("rst_enq0", 32'(enq0), 32'd0);
        send(8'h5A, 16'h0000);
        check("post_rst_bits0", 32'(cap0[7:0]), 32'h5A);

        // 0xA5, no back-pressure.
        send(8'hA5, 16'h0000);
        check("a5_bits0", 32'(cap0[7:0]), 32'hA5);
        check("a5_nbits0", 32'(ncap0), 32'd8);
        check("a5_shift0", 32'(sh0), 32'd8);
        check("a5_words0", 32'(ws0), 32'd2);

        // Same word, full during SHIFT cycles 3-5.
        send(8'hA5, 16'h001C);
        check("stall_bits0", 32'(cap0[7:0]), 32'hA5);
        check("stall_nbits0", 32'(ncap0), 32'd8);
        check("stall_shift0", 32'(sh0), 32'd11);

        // MSB first with parity: 0x07 -> 0,0,0,0,0,1,1,1 then parity 1.
        send(8'h07, 16'h0000);
        check("msb_par_bits1", 32'(cap1[8:0]), 32'h1E0);
        check("msb_par_nbits1", 32'(ncap1), 32'd9);

        // New word held valid throughout SHIFT is only taken once idle.
        clear_cap();
        cycle(1'b1, 8'h3C, 1'b0);
        repeat (12) cycle(1'b1, 8'hC3, 1'b0);
        drain(1'b0, 8'h00, 16'h0000);
        check("hold_nbits0", 32'(ncap0), 32'd16);
        check("hold_bits0", 32'(cap0), 32'hC33C);

        // Random traffic with random back-pressure.
        for (int n = 0; n < 400; n++)
            cycle(1'($urandom % 2), 8'($urandom), 1'(($urandom % 4) == 0));
        drain(1'b0, 8'h00, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
